usb_tx_bit_sched: RTL

Transmit bit-level scheduler for the USB full-speed TX path. It sits between the TX byte source (packet FIFO/PID logic) and the NRZI encoder. It sequences a bit-period timer, serialises bytes LSB-first, and inserts USB stuff bits. It then drives the EOP sequence and reports completion.

---
 rtl/usb_tx_pkg.sv | 17 +
 rtl/tx_flex_counter.sv | 29 ++
 rtl/usb_tx_bit_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB full-speed TX bit scheduler
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;
  localparam logic [2:0] STUFF_LIMIT   = 3'd6;
  localparam logic [1:0] EOP_SE0_BITS  = 2'd2;

endpackage

// File: rtl/tx_flex_counter.sv
// rtl/tx_flex_counter.sv - bit-period timer counting 1..rollover_val and rolling over to 1
module tx_flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count;

  // A clear that lands with count_enable starts a fresh period at 1, so the
  // period that follows a state change is exactly rollover_val cycles long.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= count_enable ? NUM_CNT_BITS'(1) : '0;
    end else if (count_enable) begin
      count <= (count == rollover_val) ? NUM_CNT_BITS'(1) : count + 1'b1;
    end
  end

  assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/usb_tx_bit_sched.sv
// rtl/usb_tx_bit_sched.sv - USB FS TX bit scheduler: serialises bytes, stuffs bits, drives EOP
module usb_tx_bit_sched
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int NUM_CNT_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  input  logic       byte_valid,
  input  logic       last_byte,
  output logic       byte_req,
  output logic       tx_bit,
  output logic       se0,
  output logic       bit_strobe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [NUM_CNT_BITS-1:0] ROLL_VAL = NUM_CNT_BITS'(CLKS_PER_BIT);

  tx_state_e  state;
  logic [7:0] shreg;
  logic [7:0] buf_data;
  logic       buf_full;
  logic       buf_last;
  logic       cur_last;
  logic       last_acc;
  logic [3:0] bit_cnt;
  logic [2:0] ones;
  logic [1:0] eop_cnt;

  logic       active;
  logic       abort_hit;
  logic       load_go;
  logic       cnt_roll;
  logic       byte_xfer;
  logic [2:0] ones_next;
  logic       stuff_now;
  logic       boundary;

  assign busy      = (state != ST_IDLE);
  assign active    = (state inside {ST_LOAD, ST_SHIFT, ST_STUFF});
  assign abort_hit = abort && active;
  assign load_go   = (state == ST_LOAD) && buf_full;
  assign byte_req  = active && !buf_full && !last_acc;
  assign byte_xfer = byte_req && byte_valid;

  assign bit_strobe = cnt_roll && busy && (state != ST_LOAD);
  assign tx_bit     = (state == ST_SHIFT) ? shreg[0] : (state != ST_STUFF);
  assign se0        = (state == ST_EOP_SE0);

  assign ones_next = tx_bit ? ones + 3'd1 : 3'd0;
  assign stuff_now = (state == ST_SHIFT) && (ones_next == STUFF_LIMIT);
  // Byte boundary: last data bit with no stuff due, or a stuff bit deferred past it.
  assign boundary  = bit_strobe &&
                     (((state == ST_SHIFT) && !stuff_now && (bit_cnt == BITS_PER_BYTE - 4'd1)) ||
                      ((state == ST_STUFF) && (bit_cnt == BITS_PER_BYTE)));

  tx_flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_bit_timer (
    .clk          (clk),
    .n_rst        (~rst),
    .clear        (!busy || (state == ST_LOAD) || abort_hit),
    .count_enable ((busy && (state != ST_LOAD)) || load_go || abort_hit),
    .rollover_val (ROLL_VAL),
    .rollover_flag(cnt_roll)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      buf_last <= 1'b0;
      cur_last <= 1'b0;
      last_acc <= 1'b0;
      bit_cnt  <= '0;
      ones     <= '0;
      eop_cnt  <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      if (byte_xfer) begin
        buf_full <= 1'b1;
        buf_data <= tx_byte;
        buf_last <= last_byte;
        if (last_byte) last_acc <= 1'b1;
      end
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_LOAD;
          buf_full <= 1'b0;
          last_acc <= 1'b0;
          ones     <= '0;
          bit_cnt  <= '0;
        end
        ST_LOAD: if (buf_full) begin
          shreg    <= buf_data;
          cur_last <= buf_last;
          buf_full <= 1'b0;
          bit_cnt  <= '0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: if (bit_strobe) begin
          ones    <= stuff_now ? 3'd0 : ones_next;
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (stuff_now) state <= ST_STUFF;
        end
        ST_STUFF: if (bit_strobe) begin
          ones <= '0;
          if (!boundary) state <= ST_SHIFT;
        end
        ST_EOP_SE0: if (bit_strobe) begin
          if (eop_cnt == EOP_SE0_BITS - 2'd1) state <= ST_EOP_J;
          else eop_cnt <= eop_cnt + 2'd1;
        end
        ST_EOP_J: if (bit_strobe) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (boundary) begin
        if (buf_full) begin
          shreg    <= buf_data;
          cur_last <= buf_last;
          buf_full <= 1'b0;
          bit_cnt  <= '0;
          state    <= ST_SHIFT;
        end else begin
          state    <= ST_EOP_SE0;
          eop_cnt  <= '0;
          underrun <= !cur_last;
        end
      end
      if (abort_hit) begin
        state    <= ST_EOP_SE0;
        eop_cnt  <= '0;
        buf_full <= 1'b0;
      end
    end
  end

endmodule
